// File: rtl/ttl_csum_update_pkg.sv
// Shared constants, FSM state type and the incremental IPv4 checksum helper
// for the TTL decrement / checksum rewrite stage.
package ttl_csum_update_pkg;

  localparam int unsigned ETHERTYPE_HI = 159;
  localparam int unsigned ETHERTYPE_LO = 144;
  localparam int unsigned VER_HI       = 143;
  localparam int unsigned VER_LO       = 140;
  localparam int unsigned TTL_HI       = 79;
  localparam int unsigned TTL_LO       = 72;
  localparam int unsigned PROTO_HI     = 71;
  localparam int unsigned PROTO_LO     = 64;
  localparam int unsigned CSUM_HI      = 63;
  localparam int unsigned CSUM_LO      = 48;

  localparam logic [15:0] ETH_IPV4      = 16'h0800;
  // Odd port bits of the one-hot port vectors are CPU queues
  localparam logic [7:0]  CPU_PORT_MASK = 8'hAA;

  typedef enum logic {
    HDR  = 1'b0,
    BODY = 1'b1
  } state_t;

  // RFC 1624 eq. 3: HC' = ~(~HC + ~m + m'), carries folded back twice
  function automatic logic [15:0] csum_incr(input logic [15:0] hc,
                                            input logic [15:0] m_old,
                                            input logic [15:0] m_new);
    logic [17:0] sum;
    logic [16:0] fold1;
    logic [15:0] fold2;
    sum   = {2'b00, ~hc} + {2'b00, ~m_old} + {2'b00, m_new};
    fold1 = {1'b0, sum[15:0]} + {15'b0, sum[17:16]};
    fold2 = fold1[15:0] + {15'b0, fold1[16]};
    return ~fold2;
  endfunction

endpackage

// File: rtl/ttl_csum_update_skid.sv
// Two-entry AXI4-Stream skid buffer (main + skid register) with a registered
// ready, giving one-cycle latency and full throughput.
module axis_skid_buffer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] s_data_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  output logic [W-1:0] m_data_o,
  output logic         m_valid_o,
  input  logic         m_ready_i
);

  logic [W-1:0] main_data_q, main_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         ready_q, ready_d;
  logic         accept;

  assign accept = s_valid_i & ready_q;

  always_comb begin
    main_data_d  = main_data_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (!main_valid_q || m_ready_i) begin
      // Skid entry drains first so beat order is preserved
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_data_d = s_data_i;
      end
    end else if (accept) begin
      skid_data_d  = s_data_i;
      skid_valid_d = 1'b1;
    end
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_data_q  <= '0;
      skid_data_q  <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign s_ready_o = ready_q;
  assign m_data_o  = main_data_q;
  assign m_valid_o = main_valid_q;

endmodule

// File: rtl/ttl_csum_update.sv
// Decrements TTL and incrementally patches the IPv4 header checksum of
// MAC-to-MAC forwarded IPv4 packets; everything else passes through.
module ttl_csum_update
  import ttl_csum_update_pkg::*;
#(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned SRC_PORT_POS       = 16,
  parameter int unsigned DST_PORT_POS       = 24,
  parameter int unsigned C_CNT_WIDTH        = 32
) (
  input  logic                             AXI_ACLK,
  input  logic                             reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]    S_AXIS_TUSER,
  input  logic                             S_AXIS_TVALID,
  output logic                             S_AXIS_TREADY,
  input  logic                             S_AXIS_TLAST,
  output logic [C_AXIS_DATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic [C_AXIS_TUSER_WIDTH-1:0]    M_AXIS_TUSER,
  output logic                             M_AXIS_TVALID,
  input  logic                             M_AXIS_TREADY,
  output logic                             M_AXIS_TLAST,
  input  logic                             clear_counters,
  output logic [C_CNT_WIDTH-1:0]           pkt_count,
  output logic [C_CNT_WIDTH-1:0]           ttl_dec_count
);

  localparam int unsigned STRB_W = C_AXIS_DATA_WIDTH / 8;
  localparam int unsigned SKID_W = 1 + C_AXIS_TUSER_WIDTH + STRB_W + C_AXIS_DATA_WIDTH;

  state_t                   state_q, state_d;
  logic                     accept;
  logic                     s_ready;
  logic                     eligible;
  logic                     rewrite;
  logic [7:0]               src_ports, dst_ports;
  logic [7:0]               ttl, ttl_new, proto;
  logic [15:0]              hc;
  logic [C_AXIS_DATA_WIDTH-1:0] tdata_mod;
  logic [C_CNT_WIDTH-1:0]   pkt_count_q, ttl_dec_count_q;
  logic [SKID_W-1:0]        skid_out;

  assign accept    = S_AXIS_TVALID & s_ready;
  assign src_ports = S_AXIS_TUSER[SRC_PORT_POS +: 8];
  assign dst_ports = S_AXIS_TUSER[DST_PORT_POS +: 8];
  assign ttl       = S_AXIS_TDATA[TTL_HI:TTL_LO];
  assign proto     = S_AXIS_TDATA[PROTO_HI:PROTO_LO];
  assign hc        = S_AXIS_TDATA[CSUM_HI:CSUM_LO];
  assign ttl_new   = ttl - 8'd1;

  assign eligible = (S_AXIS_TDATA[ETHERTYPE_HI:ETHERTYPE_LO] == ETH_IPV4) &&
                    (S_AXIS_TDATA[VER_HI:VER_LO] == 4'd4) &&
                    (ttl >= 8'd2) &&
                    ((src_ports & CPU_PORT_MASK) == 8'h00) &&
                    (dst_ports != 8'h00) &&
                    ((dst_ports & CPU_PORT_MASK) == 8'h00);

  always_ff @(posedge AXI_ACLK) begin
    if (reset) state_q <= HDR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HDR:  if (accept && !S_AXIS_TLAST) state_d = BODY;
      BODY: if (accept &&  S_AXIS_TLAST) state_d = HDR;
    endcase
  end

  // Rewrite is applied before buffering so the skid buffer only moves data
  always_comb begin
    rewrite   = (state_q == HDR) && eligible;
    tdata_mod = S_AXIS_TDATA;
    if (rewrite) begin
      tdata_mod[TTL_HI:TTL_LO]   = ttl_new;
      tdata_mod[CSUM_HI:CSUM_LO] = csum_incr(hc, {ttl, proto}, {ttl_new, proto});
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (reset || clear_counters) begin
      pkt_count_q     <= '0;
      ttl_dec_count_q <= '0;
    end else begin
      if (accept && S_AXIS_TLAST) pkt_count_q     <= pkt_count_q + C_CNT_WIDTH'(1);
      if (accept && rewrite)      ttl_dec_count_q <= ttl_dec_count_q + C_CNT_WIDTH'(1);
    end
  end

  assign pkt_count     = pkt_count_q;
  assign ttl_dec_count = ttl_dec_count_q;

  axis_skid_buffer #(
    .W(SKID_W)
  ) u_skid (
    .clk_i     (AXI_ACLK),
    .rst_i     (reset),
    .s_data_i  ({S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, tdata_mod}),
    .s_valid_i (S_AXIS_TVALID),
    .s_ready_o (s_ready),
    .m_data_o  (skid_out),
    .m_valid_o (M_AXIS_TVALID),
    .m_ready_i (M_AXIS_TREADY)
  );

  assign S_AXIS_TREADY = s_ready;
  assign {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TDATA} = skid_out;

endmodule

// File: tb/tb_ttl_csum_update.sv
// Directed and randomized bench for ttl_csum_update against a packet-level
// reference model of the TTL/checksum rewrite and the statistics counters.
module tb_ttl_csum_update;

  typedef struct {
    logic [255:0] d;
    logic [31:0]  s;
    logic [127:0] u;
    logic         l;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] S_AXIS_TDATA = '0;
  logic [31:0]  S_AXIS_TSTRB = '0;
  logic [127:0] S_AXIS_TUSER = '0;
  logic         S_AXIS_TVALID = 1'b0;
  logic         S_AXIS_TREADY;
  logic         S_AXIS_TLAST = 1'b0;
  logic [255:0] M_AXIS_TDATA;
  logic [31:0]  M_AXIS_TSTRB;
  logic [127:0] M_AXIS_TUSER;
  logic         M_AXIS_TVALID;
  logic         M_AXIS_TREADY = 1'b1;
  logic         M_AXIS_TLAST;
  logic         clear_counters = 1'b0;
  logic [31:0]  pkt_count, ttl_dec_count;

  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  logic [31:0]  exp_pkt = '0;
  logic [31:0]  exp_dec = '0;
  int unsigned  cyc = 0;
  bit           bp_en = 1'b0;
  bit           ready_force = 1'b1;
  beat_t        expq[$];
  logic [255:0] out_log[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ttl_csum_update #(
    .C_AXIS_DATA_WIDTH (256),
    .C_AXIS_TUSER_WIDTH(128),
    .SRC_PORT_POS      (16),
    .DST_PORT_POS      (24),
    .C_CNT_WIDTH       (32)
  ) dut (
    .AXI_ACLK      (clk),
    .reset         (reset),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TSTRB  (S_AXIS_TSTRB),
    .S_AXIS_TUSER  (S_AXIS_TUSER),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TSTRB  (M_AXIS_TSTRB),
    .M_AXIS_TUSER  (M_AXIS_TUSER),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .clear_counters(clear_counters),
    .pkt_count     (pkt_count),
    .ttl_dec_count (ttl_dec_count)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain one's-complement arithmetic: ~(~HC + ~m + m') with repeated carry fold
  function automatic logic [15:0] ref_csum(input logic [15:0] hc, input logic [15:0] mo,
                                           input logic [15:0] mn);
    logic [15:0] nh, nm;
    logic [31:0] acc;
    nh  = ~hc;
    nm  = ~mo;
    acc = {16'h0, nh} + {16'h0, nm} + {16'h0, mn};
    while (acc > 32'h0000FFFF) acc = (acc & 32'h0000FFFF) + (acc >> 16);
    return ~acc[15:0];
  endfunction

  function automatic bit ref_eligible(input logic [15:0] eth, input logic [3:0] ver,
                                      input logic [7:0] ttl, input logic [7:0] src,
                                      input logic [7:0] dst);
    return (eth == 16'h0800) && (ver == 4'd4) && (ttl >= 8'd2) &&
           ((src & 8'hAA) == 8'h00) && (dst != 8'h00) && ((dst & 8'hAA) == 8'h00);
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b.s = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFFFFFF;
    b.u = {$urandom, $urandom, $urandom, $urandom};
    b.l = 1'b0;
    return b;
  endfunction

  // Random TREADY changes 2 time units after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      M_AXIS_TREADY = bp_en ? ($urandom_range(0, 99) < 30) : ready_force;
    end
  end

  // Output monitor: ordering/content vs expected queue, and AXI hold-while-stalled
  logic  stall_q = 1'b0;
  beat_t held;
  always @(negedge clk) begin
    if (reset) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_valid", M_AXIS_TVALID, 1);
        chk("hold_data", M_AXIS_TDATA, held.d);
        chk("hold_side", {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TSTRB}, {held.l, held.u, held.s});
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        out_log.push_back(M_AXIS_TDATA);
        chk("beat_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          beat_t e;
          e = expq.pop_front();
          chk("out_data", M_AXIS_TDATA, e.d);
          chk("out_side", {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TSTRB}, {e.l, e.u, e.s});
        end
      end
      stall_q <= M_AXIS_TVALID && !M_AXIS_TREADY;
      held.d  <= M_AXIS_TDATA;
      held.s  <= M_AXIS_TSTRB;
      held.u  <= M_AXIS_TUSER;
      held.l  <= M_AXIS_TLAST;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat was accepted
  task automatic send_beat(input beat_t b, input beat_t e, input bit rew, input bit clr);
    int unsigned w;
    S_AXIS_TDATA   = b.d;
    S_AXIS_TSTRB   = b.s;
    S_AXIS_TUSER   = b.u;
    S_AXIS_TLAST   = b.l;
    S_AXIS_TVALID  = 1'b1;
    clear_counters = clr;
    w = 0;
    @(negedge clk);
    while (!S_AXIS_TREADY) begin
      w++;
      if (w > 1000) begin
        n_err++;
        $display("FAIL send_timeout: S_AXIS_TREADY stuck low for %0d cycles", w);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "input handshake timeout");
      end
      @(negedge clk);
    end
    @(posedge clk);
    expq.push_back(e);
    if (b.l) exp_pkt++;
    if (rew) exp_dec++;
    if (clr) begin
      exp_pkt = '0;
      exp_dec = '0;
    end
    #1;
    S_AXIS_TVALID  = 1'b0;
    clear_counters = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] eth, input logic [3:0] ver, input logic [7:0] ttl,
                          input logic [7:0] proto, input logic [15:0] hc, input logic [7:0] src,
                          input logic [7:0] dst, input int unsigned nbeats,
                          input int unsigned nsend, input bit clr_last);
    beat_t b, e;
    bit    rew;
    for (int unsigned i = 0; i < nsend; i++) begin
      b = rand_beat();
      b.l = (i == nbeats - 1);
      b.u[23:16] = src;
      b.u[31:24] = dst;
      if (i == 0) begin
        b.d[159:144] = eth;
        b.d[143:140] = ver;
        b.d[79:72]   = ttl;
        b.d[71:64]   = proto;
        b.d[63:48]   = hc;
      end
      e   = b;
      rew = (i == 0) && ref_eligible(eth, ver, ttl, src, dst);
      if (rew) begin
        e.d[79:72] = ttl - 8'd1;
        e.d[63:48] = ref_csum(hc, {ttl, proto}, {ttl - 8'd1, proto});
      end
      send_beat(b, e, rew, clr_last && b.l);
    end
  endtask

  task automatic drain();
    int unsigned w;
    w = 0;
    while ((expq.size() != 0 || M_AXIS_TVALID) && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain_in_time", w < 500, 1);
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_pkt_count"}, pkt_count, exp_pkt);
    chk({tag, "_ttl_dec_count"}, ttl_dec_count, exp_dec);
  endtask

  task automatic chk_hdr(input string tag, input int unsigned idx, input logic [7:0] ttl,
                         input logic [15:0] hc);
    logic [255:0] t;
    t = out_log[idx];
    chk({tag, "_ttl"}, t[79:72], ttl);
    chk({tag, "_hc"}, t[63:48], hc);
  endtask

  task automatic send_random_pkt();
    logic [15:0] eth;
    logic [7:0]  ttl, src, dst;
    int unsigned r, n;
    r   = $urandom_range(0, 9);
    eth = (r < 7) ? 16'h0800 : (r == 7) ? 16'h0806 : 16'($urandom);
    ttl = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
    src = 8'h01 << $urandom_range(0, 7);
    r   = $urandom_range(0, 3);
    dst = (r == 0) ? 8'h00 : (r == 1) ? 8'($urandom) : (8'h01 << $urandom_range(0, 7));
    n   = $urandom_range(1, 4);
    send_pkt(eth, ($urandom_range(0, 9) == 0) ? 4'd6 : 4'd4, ttl, 8'($urandom),
             16'($urandom), src, dst, n, n, 1'b0);
  endtask

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned idx, c0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_m_tvalid", M_AXIS_TVALID, 0);
    chk("rst_s_tready", S_AXIS_TREADY, 1);
    chk("rst_m_tdata", M_AXIS_TDATA, 0);
    chk("rst_m_side", {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TSTRB}, 0);
    chk_counters("rst");
    @(posedge clk);
    #1;

    // Eligible 3-beat packet
    idx = out_log.size();
    send_pkt(16'h0800, 4'd4, 8'h40, 8'h11, 16'hB1E6, 8'h01, 8'h04, 3, 3, 1'b0);
    drain();
    chk_hdr("elig", idx, 8'h3F, 16'hB2E6);
    chk_counters("elig");

    // Ineligible cases: bit-exact pass, ttl_dec_count unchanged
    send_pkt(16'h0800, 4'd4, 8'h01, 8'h11, 16'h1234, 8'h01, 8'h04, 2, 2, 1'b0);
    send_pkt(16'h0806, 4'd4, 8'h40, 8'h11, 16'h1234, 8'h01, 8'h04, 2, 2, 1'b0);
    send_pkt(16'h0800, 4'd4, 8'h40, 8'h11, 16'h1234, 8'h01, 8'h02, 1, 1, 1'b0);
    send_pkt(16'h0800, 4'd4, 8'h40, 8'h11, 16'h1234, 8'h02, 8'h04, 3, 3, 1'b0);
    drain();
    chk_counters("inelig");
    chk("inelig_dec_unchanged", ttl_dec_count, 1);

    // Checksum end-around carry
    idx = out_log.size();
    send_pkt(16'h0800, 4'd4, 8'h02, 8'h06, 16'hFFFE, 8'h01, 8'h04, 2, 2, 1'b0);
    drain();
    chk_hdr("wrap", idx, 8'h01, 16'h00FF);
    chk_counters("wrap");

    // Back-to-back single-beat eligible packets after a standalone clear
    clear_counters = 1'b1;
    @(posedge clk);
    #1 clear_counters = 1'b0;
    exp_pkt = '0;
    exp_dec = '0;
    idx = out_log.size();
    for (int unsigned i = 0; i < 4; i++)
      send_pkt(16'h0800, 4'd4, 8'(8'h10 + i), 8'h06, 16'(16'h2000 + i), 8'h04, 8'h10, 1, 1, 1'b0);
    drain();
    for (int unsigned i = 0; i < 4; i++)
      chk_hdr("single", idx + i, 8'(8'h0F + i),
              ref_csum(16'(16'h2000 + i), {8'(8'h10 + i), 8'h06}, {8'(8'h0F + i), 8'h06}));
    chk("single_pkt_count", pkt_count, 4);
    chk_counters("single");

    // Full throughput with TREADY held high
    c0 = cyc;
    for (int unsigned i = 0; i < 5; i++)
      send_pkt(16'h0800, 4'd4, 8'h80, 8'h11, 16'($urandom), 8'h01, 8'h40, 4, 4, 1'b0);
    chk("throughput_cycles", cyc - c0, 20);
    drain();
    chk_counters("thru");

    // Random backpressure, mixed traffic
    bp_en = 1'b1;
    for (int unsigned i = 0; i < 100; i++) send_random_pkt();
    bp_en = 1'b0;
    drain();
    chk_counters("bp");

    // Reset while a header beat is stalled in the buffer
    ready_force = 1'b0;
    send_pkt(16'h0800, 4'd4, 8'h40, 8'h11, 16'hB1E6, 8'h01, 8'h04, 3, 1, 1'b0);
    reset = 1'b1;
    expq.delete();
    exp_pkt = '0;
    exp_dec = '0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_m_tvalid", M_AXIS_TVALID, 0);
    chk("midrst_m_tdata", M_AXIS_TDATA, 0);
    chk("midrst_s_tready", S_AXIS_TREADY, 1);
    chk_counters("midrst");
    @(posedge clk);
    #1 reset = 1'b0;
    ready_force = 1'b1;
    @(posedge clk);
    #1;
    idx = out_log.size();
    send_pkt(16'h0800, 4'd4, 8'h40, 8'h11, 16'hB1E6, 8'h01, 8'h04, 2, 2, 1'b0);
    drain();
    chk_hdr("postrst", idx, 8'h3F, 16'hB2E6);
    chk_counters("postrst");

    // clear_counters coincident with an accepted TLAST beat of a rewritten packet
    send_pkt(16'h0800, 4'd4, 8'h20, 8'h11, 16'h4321, 8'h01, 8'h04, 2, 2, 1'b1);
    drain();
    chk("clr_pkt_zero", pkt_count, 0);
    chk("clr_dec_zero", ttl_dec_count, 0);
    send_pkt(16'h0800, 4'd4, 8'h20, 8'h11, 16'h4321, 8'h01, 8'h04, 1, 1, 1'b0);
    drain();
    chk_counters("after_clr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ttl_csum_update.md
Name: ttl_csum_update

Overview:
- Stage directly downstream of the destination-IP / CPU-punt stage in the router output-port-lookup pipeline; consumes its AXI4-Stream output after destination ports are written into TUSER.
- For IPv4 packets forwarded from a MAC port to a MAC port, it decrements the TTL and incrementally rewrites the IPv4 header checksum on the first beat.
- All other packets pass through unmodified, including packets to or from the CPU.
- Registered, one-beat-latency pipeline with full backpressure support.

Parameters:
- C_AXIS_DATA_WIDTH, 256, stream data width; only 256 is supported.
- C_AXIS_TUSER_WIDTH, 128, stream TUSER width.
- SRC_PORT_POS, 16, LSB of the 8-bit source-port one-hot in TUSER.
- DST_PORT_POS, 24, LSB of the 8-bit destination-port one-hot in TUSER.
- C_CNT_WIDTH, 32, width of the statistics counters.

Ports:
- AXI_ACLK  in  1  clock
- reset  in  1  synchronous, active-high reset
- S_AXIS_TDATA  in  256  input beat data
- S_AXIS_TSTRB  in  32  byte strobes
- S_AXIS_TUSER  in  128  sideband
- S_AXIS_TVALID  in  1  input valid
- S_AXIS_TREADY  out  1  input ready
- S_AXIS_TLAST  in  1  last beat
- M_AXIS_TDATA  out  256  output data
- M_AXIS_TSTRB  out  32  output strobes
- M_AXIS_TUSER  out  128  output sideband, passed unchanged
- M_AXIS_TVALID  out  1  output valid
- M_AXIS_TREADY  in  1  downstream ready
- M_AXIS_TLAST  out  1  last beat
- clear_counters  in  1  synchronous counter clear, level
- pkt_count  out  C_CNT_WIDTH  packets passed (TLAST beats accepted)
- ttl_dec_count  out  C_CNT_WIDTH  packets rewritten

Behaviour:
- Reset is synchronous, active-high, on AXI_ACLK.
  - M_AXIS_TVALID=0; S_AXIS_TREADY=1 on the first cycle after reset; all counters 0; FSM=HDR.
  - Data/TSTRB/TUSER/TLAST output registers reset to 0.
- Buffering: two-entry skid buffer (main register plus skid register).
  - Latency is exactly 1 cycle from input acceptance to M_AXIS_TVALID.
  - Sustains 1 beat/cycle when M_AXIS_TREADY=1.
  - S_AXIS_TREADY is registered; it is deasserted only when the skid entry is occupied.
  - Output remains stable while TVALID=1 and TREADY=0 (AXI rule). No beat is dropped or duplicated.
- FSM, advanced on accepted input beats:
  - HDR --(accept and !TLAST)--> BODY.
  - HDR --(accept and TLAST)--> HDR (single-beat packet; still eligible).
  - BODY --(accept and TLAST)--> HDR.
- Field positions on the first beat (byte 0 at [255:248]):
  - ethertype [159:144]
  - version [143:140]
  - TTL [79:72]
  - protocol [71:64]
  - header checksum [63:48]
- Eligibility, evaluated only in HDR, all conditions required:
  - ethertype==16'h0800
  - version==4
  - TTL>=2
  - no odd (CPU) bit set in the source-port one-hot
  - DST one-hot nonzero, with no odd (CPU) bit set
- Rewrite, applied on the accepted HDR beat when eligible:
  - TTL'=TTL-1.
  - m={TTL,proto}, m'={TTL',proto}.
  - HC'=~(~HC + ~m + m'), using a 16-bit one's-complement sum: 18-bit intermediate, end-around carry folded twice (RFC 1624 eq. 3).
  - All other bits unchanged.
- Non-eligible packets and BODY beats pass through bit-exact.
- Counters:
  - pkt_count += 1 per accepted TLAST beat.
  - ttl_dec_count += 1 per rewritten header.
  - Counters wrap modulo 2^C_CNT_WIDTH.
  - clear_counters has priority over increments in the same cycle; it does not affect the data path.
- Reset asserted mid-packet: buffered beats are discarded and FSM returns to HDR. The next accepted beat is treated as a header; upstream is also reset by the same signal.
- TSTRB is forwarded unchanged; it is not used for field qualification.

Decomposition:
- Shared package: field bit-offset constants (ETHERTYPE_HI/LO, VER_HI/LO, TTL_HI/LO, PROTO_HI/LO, CSUM_HI/LO), ETH_IPV4=16'h0800, FSM state encoding (HDR, BODY), function csum_incr(hc, m_old, m_new).
- One natural sub-module: axis_skid_buffer (parameterised width; carries {TLAST, TUSER, TSTRB, TDATA}).
- Rewrite logic and counters live in the top module.

Test Plan:
- Eligible single packet:
  - Stimulus: ethertype 0800, ver 4, TTL 0x40, proto 0x11, HC 0xB1E6, src port bit0, dst bit2, 3 beats.
  - Required: TTL 0x3F, HC 0xB2E6; beats 2-3 bit-exact; ttl_dec_count=1, pkt_count=1.
- Ineligible cases, each must pass bit-exact with ttl_dec_count unchanged:
  - TTL=1
  - ethertype 0x0806
  - dst one-hot 8'b00000010 (CPU)
  - src bit1 (from CPU)
- Checksum wrap:
  - Stimulus: HC 0xFFFE, TTL 0x02, proto 0x06.
  - Required: HC' = 0xFFFE + 0x0100 in one's-complement, i.e. 0x00FF; TTL 0x01.
- Backpressure:
  - Stimulus: random M_AXIS_TREADY at 30% and continuous input of 100 mixed packets.
  - Required: output stream equals the reference model; no drop or duplication; output held stable while stalled; full throughput once TREADY=1.
- Back-to-back single-beat packets:
  - Stimulus: 4 TLAST-on-first-beat eligible packets.
  - Required: each is rewritten; pkt_count=4.
- Reset and clear:
  - Stimulus: assert reset mid-packet, then issue clear_counters coincident with a TLAST beat.
  - Required: M_AXIS_TVALID=0 on the next cycle and FSM returns to HDR; after clear_counters, counters read 0.
